pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the hold and bubble controls
//  of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers from four causes:
//   - load-use hazards
//   - taken branches resolved in MEM
//   - I-cache busy-wait
//   - D-cache busy-wait
//  It also counts stall/flush events and flags a hung memory.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 30 +++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared encodings for the pipeline stall/flush sequencer. The
//            debug monitor and verification components import these too.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Registered cause of the previous cycle, visible on STATE
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_IWAIT = 2'd2,
        ST_LUSE  = 2'd3
    } state_t;

    // ID/EX mem-read code meaning "not a load"
    localparam logic [2:0] c_MEM_READ_NONE = 3'b000;

    // Width of the consecutive-busy watchdog counter
    localparam int c_BUSY_RUN_W = 16;

    // Saturating increment so the watchdog never wraps back below TIMEOUT
    function automatic logic [c_BUSY_RUN_W-1:0] sat_inc(input logic [c_BUSY_RUN_W-1:0] v);
        return (v == {c_BUSY_RUN_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use compare between the instruction in ID
//            and the load sitting in ID/EX.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ID_RS1,
    input  logic [4:0] ID_RS2,
    input  logic       ID_USE_RS1,
    input  logic       ID_USE_RS2,
    input  logic [2:0] EX_MEM_READ,
    input  logic       EX_REG_WRITE,
    input  logic [4:0] EX_RD,
    output logic       LUSE_HIT
);

    logic w_is_load;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is never a real producer, so a load targeting it cannot create a hazard
    assign w_is_load = (EX_MEM_READ != c_MEM_READ_NONE) && EX_REG_WRITE && (EX_RD != 5'd0);
    assign w_rs1_hit = ID_USE_RS1 && (ID_RS1 == EX_RD);
    assign w_rs2_hit = ID_USE_RS2 && (ID_RS2 == EX_RD);
    assign LUSE_HIT  = w_is_load && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage RV32 pipeline. Resolves
//            D-cache wait, taken branch, load-use and I-cache wait by fixed
//            priority, counts stall cycles and branch flushes, and raises a
//            sticky flag when memory stays busy too long.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IMEM_BUSY,
    input  logic             DMEM_BUSY,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USE_RS1,
    input  logic             ID_USE_RS2,
    input  logic [2:0]       EX_MEM_READ,
    input  logic             EX_REG_WRITE,
    input  logic [4:0]       EX_RD,
    input  logic             MEM_BRANCH_RES,
    output logic             PC_SEL,
    output logic             STALL_PC,
    output logic             STALL_IFID,
    output logic             STALL_IDEX,
    output logic             STALL_EXMEM,
    output logic             STALL_MEMWB,
    output logic             FLUSH_IFID,
    output logic             FLUSH_IDEX,
    output logic             FLUSH_EXMEM,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_COUNT,
    output logic [CNT_W-1:0] FLUSH_COUNT,
    output logic             HANG_ERR
);

    localparam logic [c_BUSY_RUN_W-1:0] c_TIMEOUT = TIMEOUT[c_BUSY_RUN_W-1:0];

    logic                    w_luse_hit;
    logic                    w_branch_sel;
    logic                    w_busy_cycle;
    state_t                  w_next_state;
    logic [c_BUSY_RUN_W-1:0] w_busy_next;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_stall_cnt;
    logic [CNT_W-1:0]        r_flush_cnt;
    logic [c_BUSY_RUN_W-1:0] r_busy_run;
    logic                    r_hang;

    hazard_detect u_hazard_detect (
        .ID_RS1       (ID_RS1),
        .ID_RS2       (ID_RS2),
        .ID_USE_RS1   (ID_USE_RS1),
        .ID_USE_RS2   (ID_USE_RS2),
        .EX_MEM_READ  (EX_MEM_READ),
        .EX_REG_WRITE (EX_REG_WRITE),
        .EX_RD        (EX_RD),
        .LUSE_HIT     (w_luse_hit)
    );

    // Priority encoder: D-cache wait > branch > load-use > I-cache wait > run.
    // A branch or load-use hidden behind DMEM_BUSY is re-evaluated naturally on
    // release because the stalled pipeline registers keep presenting it.
    always_comb begin
        PC_SEL       = 1'b0;
        STALL_PC     = 1'b0;
        STALL_IFID   = 1'b0;
        STALL_IDEX   = 1'b0;
        STALL_EXMEM  = 1'b0;
        STALL_MEMWB  = 1'b0;
        FLUSH_IFID   = 1'b0;
        FLUSH_IDEX   = 1'b0;
        FLUSH_EXMEM  = 1'b0;
        w_branch_sel = 1'b0;
        w_busy_cycle = 1'b0;
        w_next_state = ST_RUN;
        if (!RESET_N) begin
            // Clear the pipeline while reset is held; no stalls survive reset
            FLUSH_IFID  = 1'b1;
            FLUSH_IDEX  = 1'b1;
            FLUSH_EXMEM = 1'b1;
        end else if (DMEM_BUSY) begin
            STALL_PC     = 1'b1;
            STALL_IFID   = 1'b1;
            STALL_IDEX   = 1'b1;
            STALL_EXMEM  = 1'b1;
            STALL_MEMWB  = 1'b1;
            w_busy_cycle = 1'b1;
            w_next_state = ST_DWAIT;
        end else if (MEM_BRANCH_RES) begin
            // Redirect even when the I-cache is busy; it must accept the new PC
            PC_SEL       = 1'b1;
            FLUSH_IFID   = 1'b1;
            FLUSH_IDEX   = 1'b1;
            FLUSH_EXMEM  = 1'b1;
            w_branch_sel = 1'b1;
            w_next_state = ST_RUN;
        end else if (w_luse_hit) begin
            STALL_PC     = 1'b1;
            STALL_IFID   = 1'b1;
            FLUSH_IDEX   = 1'b1;
            w_next_state = ST_LUSE;
        end else if (IMEM_BUSY) begin
            // Front end holds, a bubble enters EX and older stages drain
            STALL_PC     = 1'b1;
            STALL_IFID   = 1'b1;
            FLUSH_IDEX   = 1'b1;
            w_busy_cycle = 1'b1;
            w_next_state = ST_IWAIT;
        end
    end

    assign w_busy_next = w_busy_cycle ? sat_inc(r_busy_run) : '0;

    // State register, event counters and busy watchdog
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_busy_run  <= '0;
            r_hang      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, STALL_PC};
            r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, w_branch_sel};
            r_busy_run  <= w_busy_next;
            if (w_busy_next >= c_TIMEOUT) begin
                r_hang <= 1'b1;
            end
        end
    end

    assign STATE       = r_state;
    assign STALL_COUNT = r_stall_cnt;
    assign FLUSH_COUNT = r_flush_cnt;
    assign HANG_ERR    = r_hang;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl: vector table,
//            directed multi-cycle sequences and a random run against a
//            reference model of the priority table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int c_TO = 8;

    // {PC_SEL, STALL_PC, STALL_IFID, STALL_IDEX, STALL_EXMEM, STALL_MEMWB,
    //  FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM}
    localparam logic [8:0] c_RUN = 9'b0_00000_000;
    localparam logic [8:0] c_DW  = 9'b0_11111_000;
    localparam logic [8:0] c_BR  = 9'b1_00000_111;
    localparam logic [8:0] c_LU  = 9'b0_11000_010;
    localparam logic [8:0] c_RST = 9'b0_00000_111;

    typedef struct {
        logic       dmem;
        logic       imem;
        logic       br;
        logic [2:0] mread;
        logic       regw;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [8:0] exp_ctrl;
        logic [1:0] exp_state;
    } vec_t;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] sc;
        logic [31:0] fc;
        logic        hang;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        IMEM_BUSY, DMEM_BUSY;
    logic [4:0]  ID_RS1, ID_RS2;
    logic        ID_USE_RS1, ID_USE_RS2;
    logic [2:0]  EX_MEM_READ;
    logic        EX_REG_WRITE;
    logic [4:0]  EX_RD;
    logic        MEM_BRANCH_RES;
    logic        PC_SEL, STALL_PC, STALL_IFID, STALL_IDEX, STALL_EXMEM, STALL_MEMWB;
    logic        FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM;
    logic [1:0]  STATE;
    logic [31:0] STALL_COUNT, FLUSH_COUNT;
    logic        HANG_ERR;
    logic [8:0]  dut_ctrl;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [1:0]  m_state;
    logic [31:0] m_sc, m_fc;
    logic [15:0] m_busy;
    logic        m_hang;
    exp_t        sb_q[$];
    vec_t        tab[12];

    pipeline_hazard_ctrl #(.CNT_W(32), .TIMEOUT(c_TO)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
        .EX_MEM_READ(EX_MEM_READ), .EX_REG_WRITE(EX_REG_WRITE), .EX_RD(EX_RD),
        .MEM_BRANCH_RES(MEM_BRANCH_RES), .PC_SEL(PC_SEL), .STALL_PC(STALL_PC),
        .STALL_IFID(STALL_IFID), .STALL_IDEX(STALL_IDEX), .STALL_EXMEM(STALL_EXMEM),
        .STALL_MEMWB(STALL_MEMWB), .FLUSH_IFID(FLUSH_IFID), .FLUSH_IDEX(FLUSH_IDEX),
        .FLUSH_EXMEM(FLUSH_EXMEM), .STATE(STATE), .STALL_COUNT(STALL_COUNT),
        .FLUSH_COUNT(FLUSH_COUNT), .HANG_ERR(HANG_ERR)
    );

    assign dut_ctrl = {PC_SEL, STALL_PC, STALL_IFID, STALL_IDEX, STALL_EXMEM, STALL_MEMWB,
                       FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM};

    always #5 CLK = ~CLK;

    // Hard time bound so the run always ends
    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at %0t, limit 1000000", $time);
        $fatal(1, "time bound expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic dmem, input logic imem, input logic br,
                                input logic [2:0] mr, input logic rw, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2,
                                input logic [8:0] ec, input logic [1:0] es);
        vec_t v;
        v.dmem = dmem; v.imem = imem; v.br = br; v.mread = mr; v.regw = rw; v.rd = rd;
        v.rs1 = rs1; v.rs2 = rs2; v.use1 = u1; v.use2 = u2; v.exp_ctrl = ec; v.exp_state = es;
        return v;
    endfunction

    function automatic logic ref_luse(input vec_t v);
        return (v.mread != 3'd0) && v.regw && (v.rd != 5'd0) &&
               ((v.use1 && (v.rs1 == v.rd)) || (v.use2 && (v.rs2 == v.rd)));
    endfunction

    function automatic logic [8:0] ref_ctrl(input vec_t v);
        if (v.dmem)                    return c_DW;
        else if (v.br)                 return c_BR;
        else if (ref_luse(v) || v.imem) return c_LU;
        else                           return c_RUN;
    endfunction

    task automatic apply(input vec_t v);
        DMEM_BUSY = v.dmem; IMEM_BUSY = v.imem; MEM_BRANCH_RES = v.br;
        EX_MEM_READ = v.mread; EX_REG_WRITE = v.regw; EX_RD = v.rd;
        ID_RS1 = v.rs1; ID_RS2 = v.rs2; ID_USE_RS1 = v.use1; ID_USE_RS2 = v.use2;
    endtask

    // One clock: drive at edge+1, check control at edge+3, check registers at next edge+1
    task automatic step(input vec_t v, input bit use_tab, input string tag);
        logic [8:0] ec;
        logic [1:0] nst;
        logic       busy_cyc;
        exp_t       e;
        apply(v);
        #2;
        ec = use_tab ? v.exp_ctrl : ref_ctrl(v);
        chk({tag, " ctrl"}, 64'(dut_ctrl), 64'(ec));
        if (!use_tab) begin
            chk("no stall+flush", 64'((STALL_IFID & FLUSH_IFID) | (STALL_IDEX & FLUSH_IDEX) |
                                      (STALL_EXMEM & FLUSH_EXMEM)), 64'd0);
        end
        busy_cyc = 1'b0;
        if (v.dmem) begin
            nst = 2'd1; busy_cyc = 1'b1;
        end else if (v.br) begin
            nst = 2'd0; m_fc = m_fc + 32'd1;
        end else if (ref_luse(v)) begin
            nst = 2'd3;
        end else if (v.imem) begin
            nst = 2'd2; busy_cyc = 1'b1;
        end else begin
            nst = 2'd0;
        end
        if (ref_ctrl(v) != c_RUN && ref_ctrl(v) != c_BR) m_sc = m_sc + 32'd1;
        m_busy  = busy_cyc ? ((m_busy == 16'hFFFF) ? m_busy : m_busy + 16'd1) : 16'd0;
        if (m_busy >= 16'(c_TO)) m_hang = 1'b1;
        m_state = nst;
        e.st = use_tab ? v.exp_state : nst;
        e.sc = m_sc; e.fc = m_fc; e.hang = m_hang;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, " state"},  64'(STATE),       64'(e.st));
            chk({tag, " stalls"}, 64'(STALL_COUNT), 64'(e.sc));
            chk({tag, " flushes"},64'(FLUSH_COUNT), 64'(e.fc));
            chk({tag, " hang"},   64'(HANG_ERR),    64'(e.hang));
        end
    endtask

    // Assert reset away from an edge, check the asynchronous effect, release on negedge
    task automatic do_reset(input string tag);
        RESET_N = 1'b0;
        m_state = 2'd0; m_sc = '0; m_fc = '0; m_busy = '0; m_hang = 1'b0;
        #1;
        chk({tag, " rst ctrl"},   64'(dut_ctrl),    64'(c_RST));
        chk({tag, " rst state"},  64'(STATE),       64'd0);
        chk({tag, " rst stalls"}, 64'(STALL_COUNT), 64'd0);
        chk({tag, " rst flushes"},64'(FLUSH_COUNT), 64'd0);
        chk({tag, " rst hang"},   64'(HANG_ERR),    64'd0);
        apply(mk(0,0,0,3'd0,0,5'd0,5'd0,5'd0,0,0,c_RUN,2'd0));
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vec_t idle, imem_v, dw_br, br_v;
        RESET_N = 1'b0;
        idle   = mk(0,0,0,3'd0,0,5'd0,5'd0,5'd0,0,0,c_RUN,2'd0);
        imem_v = mk(0,1,0,3'd0,0,5'd0,5'd0,5'd0,0,0,c_LU,2'd2);
        dw_br  = mk(1,0,1,3'd0,0,5'd0,5'd0,5'd0,0,0,c_DW,2'd1);
        br_v   = mk(0,0,1,3'd0,0,5'd0,5'd0,5'd0,0,0,c_BR,2'd0);
        apply(idle);
        #3;
        do_reset("init");

        //            dm im br mread  rw rd    rs1   rs2   u1 u2 ctrl   state
        tab[0]  = mk(0, 0, 0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, c_RUN, 2'd0);
        tab[1]  = mk(0, 0, 0, 3'd2, 1, 5'd5, 5'd0, 5'd5, 0, 1, c_LU,  2'd3);
        tab[2]  = mk(0, 0, 0, 3'd2, 1, 5'd0, 5'd0, 5'd0, 0, 1, c_RUN, 2'd0);
        tab[3]  = mk(0, 0, 0, 3'd4, 1, 5'd7, 5'd7, 5'd1, 1, 0, c_LU,  2'd3);
        tab[4]  = mk(0, 0, 0, 3'd4, 1, 5'd7, 5'd7, 5'd1, 0, 1, c_RUN, 2'd0);
        tab[5]  = mk(0, 0, 0, 3'd2, 0, 5'd5, 5'd5, 5'd5, 1, 1, c_RUN, 2'd0);
        tab[6]  = mk(0, 0, 0, 3'd0, 1, 5'd5, 5'd5, 5'd5, 1, 1, c_RUN, 2'd0);
        tab[7]  = mk(0, 1, 1, 3'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, c_BR,  2'd0);
        tab[8]  = mk(0, 0, 1, 3'd2, 1, 5'd5, 5'd5, 5'd0, 1, 0, c_BR,  2'd0);
        tab[9]  = mk(0, 1, 0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, c_LU,  2'd2);
        tab[10] = mk(0, 1, 0, 3'd1, 1, 5'd9, 5'd9, 5'd0, 1, 0, c_LU,  2'd3);
        tab[11] = mk(1, 0, 1, 3'd1, 1, 5'd9, 5'd9, 5'd0, 1, 0, c_DW,  2'd1);
        for (int i = 0; i < 12; i++) begin
            step(tab[i], 1'b1, $sformatf("tab%0d", i));
        end

        // D-cache wait hides a branch for 4 cycles; flush counted once on release
        do_reset("dwait");
        for (int i = 0; i < 4; i++) step(dw_br, 1'b1, "dwait hold");
        step(br_v, 1'b1, "dwait release");
        chk("dwait flush once", 64'(FLUSH_COUNT), 64'd1);
        chk("dwait stall count", 64'(STALL_COUNT), 64'd4);

        // Watchdog: 7 busy cycles stay clear, 8 set the sticky flag
        do_reset("wd");
        for (int i = 0; i < c_TO - 1; i++) step(imem_v, 1'b1, "wd7");
        step(idle, 1'b1, "wd idle");
        chk("wd after 7", 64'(HANG_ERR), 64'd0);
        for (int i = 0; i < c_TO; i++) step(imem_v, 1'b1, "wd8");
        chk("wd after 8", 64'(HANG_ERR), 64'd1);
        step(idle, 1'b1, "wd sticky");
        step(idle, 1'b1, "wd sticky");
        chk("wd sticky", 64'(HANG_ERR), 64'd1);
        do_reset("wd clear");

        // Reset in the second cycle of a D-cache wait
        step(dw_br, 1'b1, "mid dwait");
        apply(dw_br);
        #2;
        chk("mid dwait cycle2 ctrl", 64'(dut_ctrl), 64'(c_DW));
        do_reset("mid dwait");
        step(idle, 1'b1, "post rst");

        // Random regression against the reference model
        for (int i = 0; i < 10000; i++) begin
            vec_t r;
            r = mk(($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
                   ($urandom % 2) ? 3'd0 : 3'($urandom % 8), 1'($urandom % 2),
                   5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
                   1'($urandom % 2), 1'($urandom % 2), c_RUN, 2'd0);
            step(r, 1'b0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
